// File: rtl/cnt_pkg.sv
// Shared types and defaults for the cnt_ctrl start/stop/clear controller.
package cnt_pkg;

  localparam int unsigned DIV_DEF    = 4;
  localparam int unsigned DB_CYC_DEF = 3;
  localparam int unsigned PRESC_W    = 8;
  localparam int unsigned DBCNT_W    = 5;

  typedef enum logic [1:0] {
    STOP = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  typedef struct packed {
    logic en;
    logic cres;
    logic run;
  } cnt_out_t;

endpackage

// File: rtl/cnt_ctrl_if.sv
// Button inputs, carry and count-control outputs of cnt_ctrl grouped as one bundle.
interface cnt_ctrl_if;

  logic ss_raw;
  logic clr_raw;
  logic ca;
  logic en;
  logic cres;
  logic run;

  modport master (
    output ss_raw, clr_raw, ca,
    input  en, cres, run
  );

  modport slave (
    input  ss_raw, clr_raw, ca,
    output en, cres, run
  );

endinterface

// File: rtl/cnt_debounce.sv
// Two-flop synchronizer, DB_CYC-sample debouncer and rising-edge press pulse.
// After reset the level is loaded silently, so a button held through reset never presses.
module cnt_debounce
  import cnt_pkg::*;
#(
  parameter int unsigned DB_CYC = DB_CYC_DEF
) (
  input  logic ck,
  input  logic res,
  input  logic i_raw,
  output logic o_press
);

  localparam logic [DBCNT_W-1:0] L_DB_LAST   = DBCNT_W'(DB_CYC - 1);
  localparam logic [DBCNT_W-1:0] L_INIT_LAST = DBCNT_W'(DB_CYC + 1);

  logic [1:0]         r_sync;
  logic               r_level;
  logic               r_init;
  logic               r_press;
  logic [DBCNT_W-1:0] r_cnt;
  logic               w_sample;

  assign w_sample = r_sync[1];
  assign o_press  = r_press;

  // Init window covers the synchronizer fill plus one full debounce window.
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_init  <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_press <= 1'b0;
      if (r_init) begin
        if (r_cnt == L_INIT_LAST) begin
          r_level <= w_sample;
          r_init  <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + DBCNT_W'(1);
        end
      end else if (w_sample == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == L_DB_LAST) begin
        r_level <= w_sample;
        r_press <= w_sample;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DBCNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cnt_ctrl.sv
// Start/stop/clear controller: debounced buttons drive a STOP/RUN/HOLD FSM and en prescaler.
// Optional CNT_CTRL_AUTOSTOP_EN: carry coincident with en parks the FSM in HOLD.
module cnt_ctrl
  import cnt_pkg::*;
#(
  parameter int unsigned DIV    = DIV_DEF,
  parameter int unsigned DB_CYC = DB_CYC_DEF
) (
  input  logic ck,
  input  logic res,
  input  logic ss_raw,
  input  logic clr_raw,
  input  logic ca,
  output logic en,
  output logic cres,
  output logic run
);

  localparam logic [PRESC_W-1:0] L_PRESC_LAST = PRESC_W'(DIV - 1);

  logic               w_press_ss;
  logic               w_press_clr;
  logic               w_autostop;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_presc_nxt;
  cnt_out_t           r_out;
  cnt_out_t           w_out_nxt;

  cnt_debounce #(.DB_CYC(DB_CYC)) u_db_ss (
    .ck      (ck),
    .res     (res),
    .i_raw   (ss_raw),
    .o_press (w_press_ss)
  );

  cnt_debounce #(.DB_CYC(DB_CYC)) u_db_clr (
    .ck      (ck),
    .res     (res),
    .i_raw   (clr_raw),
    .o_press (w_press_clr)
  );

`ifdef CNT_CTRL_AUTOSTOP_EN
  assign w_autostop = r_out.en & ca;
`else
  logic w_unused_ca;
  assign w_unused_ca = ca;
  assign w_autostop  = 1'b0;
`endif

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      r_state <= STOP;
      r_presc <= '0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Outputs are decided from the next state so they line up with the state register.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = '0;
    w_out_nxt   = '0;

    case (r_state)
      STOP: if (w_press_ss) w_state_nxt = RUN;
      RUN: begin
        if (w_press_ss)      w_state_nxt = STOP;
        else if (w_autostop) w_state_nxt = HOLD;
      end
      HOLD:    w_state_nxt = HOLD;
      default: w_state_nxt = STOP;
    endcase

    if (w_press_clr) w_state_nxt = STOP;

    // Prescaler restarts from 0 on every entry to RUN.
    if (w_state_nxt == RUN && r_state == RUN) begin
      w_presc_nxt = (r_presc == L_PRESC_LAST) ? '0 : r_presc + PRESC_W'(1);
    end

    w_out_nxt.run  = (w_state_nxt == RUN);
    w_out_nxt.en   = (w_state_nxt == RUN) && (w_presc_nxt == L_PRESC_LAST);
    w_out_nxt.cres = w_press_clr;
  end

  assign en   = r_out.en;
  assign cres = r_out.cres;
  assign run  = r_out.run;

endmodule

// File: tb/tb_cnt_ctrl.sv
// Self-checking bench for cnt_ctrl: window-based behavioural model plus directed literal checks.
module tb_cnt_ctrl;

  localparam int DIV    = 4;
  localparam int DB_CYC = 3;

  logic ck  = 1'b0;
  logic res = 1'b1;

  cnt_ctrl_if bus ();

  cnt_ctrl #(.DIV(DIV), .DB_CYC(DB_CYC)) dut (
    .ck      (ck),
    .res     (res),
    .ss_raw  (bus.ss_raw),
    .clr_raw (bus.clr_raw),
    .ca      (bus.ca),
    .en      (bus.en),
    .cres    (bus.cres),
    .run     (bus.run)
  );

  always #5 ck = ~ck;

  int errors = 0;
  int checks = 0;

  // Model: a press is DB_CYC synced samples in a row opposite the level, rising only.
  bit hist [2][0:4095];
  bit m_lvl [2];
  int m_win [2];
  int m_k;
  bit m_pss, m_pclr;
  int m_state;      // 0 stopped, 1 running, 2 held
  int m_runcyc;
  bit m_en, m_cres, m_run;

  function automatic bit db_step(input int ch, input bit raw);
    bit ok;
    db_step = 1'b0;
    hist[ch][m_k] = raw;
    if (m_k == DB_CYC + 2) begin
      m_lvl[ch] = hist[ch][m_k-2];
      m_win[ch] = m_k + 1;
    end else if (m_k > DB_CYC + 2 && m_k - DB_CYC + 1 >= m_win[ch]) begin
      ok = 1'b1;
      for (int i = 0; i < DB_CYC; i++)
        if (hist[ch][m_k-i-2] == m_lvl[ch]) ok = 1'b0;
      if (ok) begin
        m_lvl[ch] = !m_lvl[ch];
        m_win[ch] = m_k + 1;
        db_step   = m_lvl[ch];
      end
    end
  endfunction

  always @(posedge ck or negedge res) begin
    if (!res) begin
      m_k = 0; m_pss = 0; m_pclr = 0; m_state = 0; m_runcyc = 0;
      m_en = 0; m_cres = 0; m_run = 0;
      m_lvl[0] = 0; m_lvl[1] = 0; m_win[0] = 0; m_win[1] = 0;
    end else begin
      int nxt;
      bit ps, pc;
      m_k++;
      nxt = m_state;
      if (m_state == 0 && m_pss) nxt = 1;
      else if (m_state == 1 && m_pss) nxt = 0;
`ifdef CNT_CTRL_AUTOSTOP_EN
      else if (m_state == 1 && m_en && bus.ca) nxt = 2;
`endif
      if (m_pclr) nxt = 0;
      m_runcyc = (nxt == 1) ? ((m_state == 1) ? m_runcyc + 1 : 1) : 0;
      m_cres   = m_pclr;
      m_state  = nxt;
      m_run    = (nxt == 1);
      m_en     = m_run && (m_runcyc % DIV == 0);
      ps = db_step(0, bus.ss_raw);
      pc = db_step(1, bus.clr_raw);
      m_pss  = ps;
      m_pclr = pc;
    end
  end

  always @(negedge ck) begin
    checks++;
    if ({bus.en, bus.cres, bus.run} !== {m_en, m_cres, m_run}) begin
      errors++;
      $display("FAIL model t=%0t en/cres/run actual=%b%b%b required=%b%b%b",
               $time, bus.en, bus.cres, bus.run, m_en, m_cres, m_run);
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  // Hold the raw buttons for 5 sampled edges; returns just after the 5th edge.
  task automatic press(input bit s, input bit c);
    bus.ss_raw  = s;
    bus.clr_raw = c;
    cyc(5);
    bus.ss_raw  = 1'b0;
    bus.clr_raw = 1'b0;
  endtask

  task automatic wait_en(input string name);
    int n = 0;
    while (bus.en !== 1'b1 && n < 12) begin
      cyc(1);
      n++;
    end
    chk(name, bus.en, 1'b1);
  endtask

  initial begin
    bus.ss_raw = 1'b0; bus.clr_raw = 1'b0; bus.ca = 1'b0;
    #1 res = 1'b0;
    #2;
    chk("reset_en", bus.en, 1'b0);
    chk("reset_cres", bus.cres, 1'b0);
    chk("reset_run", bus.run, 1'b0);
    @(posedge ck); @(posedge ck); #1 res = 1'b1;
    cyc(10);

    // Two-cycle glitch is filtered
    bus.ss_raw = 1'b1; cyc(2); bus.ss_raw = 1'b0; cyc(10);
    chk("glitch_run", bus.run, 1'b0);
    chk("glitch_en", bus.en, 1'b0);

    // Start: run on 6th edge, en on every 4th RUN cycle
    press(1'b1, 1'b0);
    chk("run_pre", bus.run, 1'b0);
    cyc(1); chk("run_rise", bus.run, 1'b1);
    cyc(2); chk("en_early", bus.en, 1'b0);
    cyc(1); chk("en_first", bus.en, 1'b1);
    cyc(1); chk("en_after", bus.en, 1'b0);
    cyc(3); chk("en_second", bus.en, 1'b1);
    cyc(6);

    // Carry coincident with en
    wait_en("ca_sync_en");
    bus.ca = 1'b1; cyc(1); bus.ca = 1'b0;
`ifdef CNT_CTRL_AUTOSTOP_EN
    chk("hold_run", bus.run, 1'b0);
    chk("hold_en", bus.en, 1'b0);
    cyc(DIV); chk("hold_no_en", bus.en, 1'b0);
    press(1'b1, 1'b0); cyc(3);
    chk("hold_ss_ignored", bus.run, 1'b0);
`else
    chk("free_run", bus.run, 1'b1);
    cyc(DIV - 1); chk("free_en", bus.en, 1'b1);
    press(1'b1, 1'b0); cyc(3);
    chk("ss_stop", bus.run, 1'b0);
`endif
    cyc(8);

    // Clear from STOP/HOLD
    press(1'b0, 1'b1);
    cyc(1); chk("clr_cres", bus.cres, 1'b1); chk("clr_run", bus.run, 1'b0);
    cyc(1); chk("clr_cres_end", bus.cres, 1'b0);
    cyc(8);

    // Back to RUN, then both buttons together
    press(1'b1, 1'b0); cyc(1); chk("rerun", bus.run, 1'b1);
    cyc(10);
    press(1'b1, 1'b1);
    chk("both_pre_run", bus.run, 1'b1);
    cyc(1);
    chk("both_cres", bus.cres, 1'b1);
    chk("both_run", bus.run, 1'b0);
    chk("both_en", bus.en, 1'b0);
    cyc(1); chk("both_cres_end", bus.cres, 1'b0);
    cyc(10);

    // Reset mid-RUN with start button held through it
    press(1'b1, 1'b0); cyc(1); chk("pre_rst_run", bus.run, 1'b1);
    cyc(2);
    bus.ss_raw = 1'b1;
    @(posedge ck); #3 res = 1'b0;
    #1;
    chk("rst_en", bus.en, 1'b0);
    chk("rst_run", bus.run, 1'b0);
    chk("rst_cres", bus.cres, 1'b0);
    @(posedge ck); #1 res = 1'b1;
    cyc(20);
    chk("held_no_run", bus.run, 1'b0);
    bus.ss_raw = 1'b0; cyc(10);
    press(1'b1, 1'b0); cyc(1);
    chk("repress_run", bus.run, 1'b1);
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
